// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch (IF)
//   and data-memory (DM) requesters. One transaction is in flight at a time.
//   Each access runs MEM_LAT cycles and returns its data with a one-cycle
//   valid pulse on the owning port.
//
// Optional feature: define ARB_PERF_CNT_EN to add the perf_if_wait,
// perf_dm_wait and perf_conflict counters. They are absent by default.
//
// Ports
//   clk, reset                   clock; synchronous active-low reset
//   if_req/if_addr/if_flush      fetch request, fetch address, discard fetch
//   if_rdata/if_valid/if_stall   fetch data, completion pulse, stall
//   dm_req/dm_we/dm_func3        data request, store enable, access size/sign
//   dm_addr/dm_wdata             data address, store data
//   dm_rdata/dm_valid/dm_stall   load data, completion pulse, stall
//   mem_en/mem_we/mem_func3      memory strobe, write enable, size
//   mem_addr/mem_wdata           memory address and write data
//   mem_rdata                    memory read data
//   perf_* (optional)            wait-cycle and conflict counters
//
// state  | meaning
// IDLE   | accept a request; DM wins unless IF has waited STARVE_MAX grants
// ACCESS | address held; lat_cnt counts down to the data-capture cycle
// RESP   | owner's valid pulses for one cycle, then back to IDLE
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_func3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_dm_wait,
  output logic [31:0]       perf_conflict
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;       // 0 = IF, 1 = DM
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                flush_q, flush_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [2:0]          mem_func3_q, mem_func3_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;
  logic                grant_dm, grant_if;

  // DM has priority, but only while IF has not been passed over STARVE_MAX times.
  assign grant_dm = dm_req && (!if_req || (starve_cnt_q < STARVE_LIM));
  assign grant_if = !grant_dm && if_req && !if_flush;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    flush_d      = flush_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_func3_d  = mem_func3_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (grant_dm) begin
          owner_d     = 1'b1;
          mem_we_d    = dm_we;
          mem_func3_d = dm_func3;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          lat_cnt_d   = LAT_INIT;
          mem_en_d    = 1'b1;
          state_d     = ACCESS;
          if (if_req && (starve_cnt_q != STARVE_LIM))
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (grant_if) begin
          owner_d      = 1'b0;
          mem_we_d     = 1'b0;
          mem_func3_d  = 3'b010;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          lat_cnt_d    = LAT_INIT;
          mem_en_d     = 1'b1;
          state_d      = ACCESS;
          starve_cnt_d = 4'd0;
        end
      end
      ACCESS: begin
        if (!owner_q && if_flush) flush_d = 1'b1;
        if (lat_cnt_q == 4'd0) begin
          state_d = RESP;
          if (owner_q) begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end else if (!(flush_q || if_flush)) begin
            // A flushed fetch still completes at the memory; its data is dropped.
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        flush_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      flush_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_func3_q  <= 3'b000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      flush_q      <= flush_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_func3_q  <= mem_func3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
    end
  end

  // A flush arriving in the RESP cycle itself still kills the fetch pulse.
  assign if_valid  = if_valid_q && !if_flush;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req && !if_valid;
  assign dm_stall  = dm_req && !dm_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_func3 = mem_func3_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait_q, perf_if_wait_d;
  logic [31:0] perf_dm_wait_q, perf_dm_wait_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_if_wait_d  = perf_if_wait_q + {31'd0, if_stall};
    perf_dm_wait_d  = perf_dm_wait_q + {31'd0, dm_stall};
    perf_conflict_d = perf_conflict_q +
                      {31'd0, (state_q == IDLE) && if_req && dm_req};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_if_wait_q  <= 32'd0;
      perf_dm_wait_q  <= 32'd0;
      perf_conflict_q <= 32'd0;
    end else begin
      perf_if_wait_q  <= perf_if_wait_d;
      perf_dm_wait_q  <= perf_dm_wait_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_if_wait  = perf_if_wait_q;
  assign perf_dm_wait  = perf_dm_wait_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4). Expected
// completions and memory accesses are queued when stimulus is issued and
// checked when the DUT produces them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [2:0]  dm_func3 = '0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;
  logic [2:0]  mem_func3;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_func3(dm_func3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: fixed contents plus one overlay word written by stores.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'h0050_0093;
    return a ^ 32'h5A5A_0000 ^ {a[7:0], 24'h0};
  endfunction

  logic        st_vld = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      st_vld  <= 1'b1;
      st_addr <= mem_addr;
      st_data <= mem_wdata;
    end
  end
  assign mem_rdata = (st_vld && st_addr == mem_addr) ? st_data : rom(mem_addr);

  typedef struct packed {logic is_dm; logic [31:0] data;} cpl_t;
  typedef struct packed {logic [31:0] addr; logic we; logic [2:0] f3; logic [31:0] wdata;} acc_t;
  cpl_t cpl_q[$];
  acc_t acc_q[$];

  int          n_checks = 0, n_fail = 0;
  logic        v_if, v_dm, v_en;
  bit          hold_dm = 1'b0;
  logic [31:0] last_if = '0, last_dm = '0;
  logic        sb_st_vld = 1'b0;
  logic [31:0] sb_st_addr = '0, sb_st_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return (sb_st_vld && sb_st_addr == a) ? sb_st_data : rom(a);
  endfunction

  task automatic push_if(input logic [31:0] a, input bit completes);
    acc_q.push_back('{a, 1'b0, 3'b010, 32'h0});
    if (completes) begin
      cpl_q.push_back('{1'b0, exp_rd(a)});
      last_if = exp_rd(a);
    end
  endtask

  task automatic push_dm(input logic [31:0] a, input logic we, input logic [2:0] f3,
                         input logic [31:0] wd);
    acc_q.push_back('{a, we, f3, wd});
    if (we) begin
      cpl_q.push_back('{1'b1, last_dm});
      sb_st_vld  = 1'b1;
      sb_st_addr = a;
      sb_st_data = wd;
    end else begin
      cpl_q.push_back('{1'b1, exp_rd(a)});
      last_dm = exp_rd(a);
    end
  endtask

  // Observe one cycle at the falling edge; score accesses and completions.
  task automatic sample();
    acc_t a;
    cpl_t e;
    @(negedge clk);
    v_if = if_valid;
    v_dm = dm_valid;
    v_en = mem_en;
    if (v_en) begin
      if (acc_q.size() == 0) check_eq("acc_unexpected", 32'(v_en), 32'd0);
      else begin
        a = acc_q.pop_front();
        check_eq("acc_addr", mem_addr, a.addr);
        check_eq("acc_we", 32'(mem_we), 32'(a.we));
        check_eq("acc_func3", 32'(mem_func3), 32'(a.f3));
        if (a.we) check_eq("acc_wdata", mem_wdata, a.wdata);
      end
    end
    if (v_if || v_dm) begin
      if (cpl_q.size() == 0) check_eq("cpl_unexpected", {30'd0, v_if, v_dm}, 32'd0);
      else begin
        e = cpl_q.pop_front();
        check_eq("cpl_port", {30'd0, v_if, v_dm}, {30'd0, !e.is_dm, e.is_dm});
        check_eq("cpl_data", e.is_dm ? dm_rdata : if_rdata, e.data);
      end
    end
    if (v_if) if_req = 1'b0;
    if (v_dm && !hold_dm) dm_req = 1'b0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (cpl_q.size() == 0 && acc_q.size() == 0 && !if_req && !dm_req) begin
        done = 1'b1;
        break;
      end
      sample();
      adv();
    end
    if (!done) check_eq("drain_timeout", 32'(cpl_q.size() + acc_q.size()), 32'd0);
  endtask

  int dm_seen;
  bit if_seen;

  initial begin
    // Reset
    reset = 1'b0;
    adv(); adv();
    sample();
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_rdata", if_rdata | dm_rdata, 32'd0);
    check_eq("rst_stalls", {30'd0, if_stall, dm_stall}, 32'd0);
    adv();
    reset = 1'b1;
    adv();

    // Single fetch
    if_req = 1'b1; if_addr = 32'h8000_0004;
    push_if(32'h8000_0004, 1'b1);
    for (int c = 0; c <= 4; c++) begin
      sample();
      check_eq($sformatf("fetch_mem_en_c%0d", c), 32'(v_en), 32'(c == 1));
      check_eq($sformatf("fetch_valid_c%0d", c), 32'(v_if), 32'(c == 3));
      if (c <= 2) check_eq($sformatf("fetch_stall_c%0d", c), 32'(if_stall), 32'd1);
      if (c == 3) check_eq("fetch_rdata", if_rdata, 32'h0050_0093);
      adv();
    end

    // Simultaneous requests: DM first, then IF
    dm_req = 1'b1; dm_we = 1'b0; dm_func3 = 3'b010; dm_addr = 32'h14;
    if_req = 1'b1; if_addr = 32'h8;
    push_dm(32'h14, 1'b0, 3'b010, 32'h0);
    push_if(32'h8, 1'b1);
    for (int c = 0; c <= 8; c++) begin
      sample();
      check_eq($sformatf("simul_dm_valid_c%0d", c), 32'(v_dm), 32'(c == 3));
      check_eq($sformatf("simul_if_valid_c%0d", c), 32'(v_if), 32'(c == 7));
      check_eq($sformatf("simul_mem_en_c%0d", c), 32'(v_en), 32'(c == 1 || c == 5));
      adv();
    end

    // Starvation: DM held, IF waiting
    hold_dm = 1'b1;
    for (int k = 0; k < 4; k++) push_dm(32'h18, 1'b0, 3'b000, 32'h0);
    push_if(32'hC, 1'b1);
    push_dm(32'h18, 1'b0, 3'b000, 32'h0);
    dm_req = 1'b1; dm_we = 1'b0; dm_func3 = 3'b000; dm_addr = 32'h18;
    if_req = 1'b1; if_addr = 32'hC;
    dm_seen = 0; if_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      sample();
      if (v_dm && !if_seen) begin
        dm_seen++;
        if (dm_seen == 4) check_eq("starve_cnt_sat", 32'(dut.starve_cnt_q), 32'd4);
      end
      if (v_if) begin
        if_seen = 1'b1;
        check_eq("starve_dm_grants", 32'(dm_seen), 32'd4);
        check_eq("starve_cnt_clear", 32'(dut.starve_cnt_q), 32'd0);
        hold_dm = 1'b0;
      end
      adv();
    end
    hold_dm = 1'b0;
    check_eq("starve_if_done", 32'(if_seen), 32'd1);
    check_eq("starve_drained", 32'(cpl_q.size()), 32'd0);
    dm_req = 1'b0; if_req = 1'b0;

    // Store, then load it back
    dm_req = 1'b1; dm_we = 1'b1; dm_func3 = 3'b010; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    push_dm(32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF);
    drain(20);
    dm_we = 1'b0; dm_func3 = 3'b100;
    dm_req = 1'b1;
    push_dm(32'h10, 1'b0, 3'b100, 32'h0);
    drain(20);
    check_eq("load_back", dm_rdata, 32'hDEAD_BEEF);

    // Flush in the first ACCESS cycle
    if_req = 1'b1; if_addr = 32'h8000_0004;
    push_if(32'h8000_0004, 1'b0);
    for (int c = 0; c <= 5; c++) begin
      sample();
      check_eq($sformatf("flush_valid_c%0d", c), 32'(v_if), 32'd0);
      check_eq($sformatf("flush_rdata_c%0d", c), if_rdata, last_if);
      if (c == 1) check_eq("flush_mem_en", 32'(v_en), 32'd1);
      if (c == 3) check_eq("flush_resp", 32'(dut.state_q), 32'd2);
      if (c == 4) check_eq("flush_idle", 32'(dut.state_q), 32'd0);
      adv();
      if (c == 0) begin if_flush = 1'b1; if_req = 1'b0; end
      if (c == 1) if_flush = 1'b0;
    end

    // Reset during ACCESS
    if_req = 1'b1; if_addr = 32'h8;
    push_if(32'h8, 1'b0);
    for (int c = 0; c <= 5; c++) begin
      sample();
      check_eq($sformatf("rstacc_valid_c%0d", c), {30'd0, v_if, v_dm}, 32'd0);
      if (c == 1) check_eq("rstacc_mem_en", 32'(v_en), 32'd1);
      if (c == 2) begin
        check_eq("rstacc_state", 32'(dut.state_q), 32'd0);
        check_eq("rstacc_mem_ctl", {28'd0, mem_en, mem_we, mem_func3 != 3'b000, 1'b0}, 32'd0);
        check_eq("rstacc_mem_addr", mem_addr, 32'd0);
        check_eq("rstacc_mem_wdata", mem_wdata, 32'd0);
        check_eq("rstacc_if_rdata", if_rdata, 32'd0);
        check_eq("rstacc_dm_rdata", dm_rdata, 32'd0);
      end
      adv();
      if (c == 0) begin reset = 1'b0; if_req = 1'b0; end
      if (c == 1) reset = 1'b1;
    end
    last_if = 32'd0;
    last_dm = 32'd0;

    // New request after reset completes normally
    dm_req = 1'b1; dm_we = 1'b0; dm_func3 = 3'b010; dm_addr = 32'h10;
    push_dm(32'h10, 1'b0, 3'b010, 32'h0);
    drain(20);
    check_eq("post_reset_load", dm_rdata, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
